// File: rtl/alu_cmd_driver_pkg.sv
// Shared types and constants for the ALU command driver: FSM states, opcodes,
// one-hot operand-mux encodings and the command error predicate.
package alu_cmd_driver_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_e;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_NAND  = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_XNOR  = 4'd10;
  localparam logic [3:0] OP_SHL   = 4'd11;
  localparam logic [3:0] OP_SHR   = 4'd12;
  localparam logic [3:0] OP_NOP   = 4'd13;
  localparam logic [3:0] OP_ERROR = 4'd14;
  localparam logic [3:0] OP_RESET = 4'd15;

  localparam logic [1:0] MUXA_LOAD = 2'b10;
  localparam logic [1:0] MUXA_HOLD = 2'b01;
  localparam logic [3:0] MUXB_LOAD = 4'b0100;
  localparam logic [3:0] MUXB_ACC  = 4'b0010;
  localparam logic [3:0] MUXB_HOLD = 4'b0001;

  // Operand comparisons are passed in pre-computed so the predicate stays width-agnostic.
  function automatic logic cmd_err(input logic [3:0] op, input logic b_gt_a, input logic b_zero);
    return ((op == OP_SUB) && b_gt_a) || ((op == OP_DIV) && b_zero) || (op == OP_ERROR);
  endfunction

endpackage

// File: rtl/alu_cmd_skid.sv
// One-entry command holding buffer for the ALU command driver; used only when
// ALU_CMD_DRIVER_SKID_EN is defined. ready is registered and equals !full.
module alu_cmd_skid #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_chain,
  output logic [3:0]    out_op,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic          out_chain,
  output logic          full,
  output logic          ready
);

  logic          full_q, full_d;
  logic          ready_q;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          chain_q, chain_d;

  always_comb begin
    full_d  = full_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    chain_d = chain_q;
    if (push) begin
      full_d  = 1'b1;
      op_d    = in_op;
      a_d     = in_a;
      b_d     = in_b;
      chain_d = in_chain;
    end else if (pop) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
    end
  end

  // Payload only matters while full, so it carries no reset.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    a_q     <= a_d;
    b_q     <= b_d;
    chain_q <= chain_d;
  end

  assign out_op    = op_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_chain = chain_q;
  assign full      = full_q;
  assign ready     = ready_q;

endmodule

// File: rtl/alu_cmd_driver.sv
// ALU command driver: accepts (op, A, B) commands, sequences the ALU through
// LOAD/EXEC and returns the accumulator with an error flag. Optional one-entry
// command skid buffer enabled by defining ALU_CMD_DRIVER_SKID_EN.
module alu_cmd_driver
  import alu_cmd_driver_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic          cmd_chain,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_mux_a,
  output logic [3:0]    alu_mux_b,
  output logic [3:0]    alu_op,
  output logic          alu_reset,
  input  logic [RW-1:0] alu_acc_val,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_data,
  output logic          rsp_err
);

  state_e        state_q, state_d;
  logic          cmd_fire, rsp_fire, load_new, load_skid, enter_load;
  logic [3:0]    sel_op;
  logic [DW-1:0] sel_a, sel_b;
  logic          sel_chain;

  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, last_q, last_d;
  logic [1:0]    mux_a_q, mux_a_d;
  logic [3:0]    mux_b_q, mux_b_d, alu_op_q, alu_op_d;
  logic          alu_reset_q, alu_reset_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [RW-1:0] rsp_data_q, rsp_data_d;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid_q && rsp_ready;

`ifdef ALU_CMD_DRIVER_SKID_EN
  logic          skid_full, skid_push, skid_chain;
  logic [3:0]    skid_op;
  logic [DW-1:0] skid_a, skid_b;

  // A held command takes priority over a new one at the response handshake.
  always_comb begin
    load_skid = (state_q == RESP) && rsp_fire && skid_full;
    load_new  = cmd_fire && ((state_q == IDLE) ||
                             ((state_q == RESP) && rsp_fire && !skid_full));
    skid_push = cmd_fire && !load_new;
    sel_op    = load_skid ? skid_op    : cmd_op;
    sel_a     = load_skid ? skid_a     : cmd_a;
    sel_b     = load_skid ? skid_b     : cmd_b;
    sel_chain = load_skid ? skid_chain : cmd_chain;
  end

  alu_cmd_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (skid_push),
    .pop       (load_skid),
    .in_op     (cmd_op),
    .in_a      (cmd_a),
    .in_b      (cmd_b),
    .in_chain  (cmd_chain),
    .out_op    (skid_op),
    .out_a     (skid_a),
    .out_b     (skid_b),
    .out_chain (skid_chain),
    .full      (skid_full),
    .ready     (cmd_ready)
  );
`else
  logic cmd_ready_q;

  always_comb begin
    load_skid = 1'b0;
    load_new  = cmd_fire && (state_q == IDLE);
    sel_op    = cmd_op;
    sel_a     = cmd_a;
    sel_b     = cmd_b;
    sel_chain = cmd_chain;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cmd_ready_q <= 1'b0;
    else       cmd_ready_q <= (state_d == IDLE);
  end

  assign cmd_ready = cmd_ready_q;
`endif

  assign enter_load = load_new || load_skid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_new) state_d = LOAD;
      LOAD:    state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = enter_load ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    mux_a_d    = MUXA_HOLD;
    mux_b_d    = MUXB_HOLD;
    if (enter_load) begin
      alu_a_d  = sel_a;
      alu_b_d  = sel_chain ? last_q : sel_b;
      alu_op_d = sel_op;
      mux_a_d  = MUXA_LOAD;
      mux_b_d  = sel_chain ? MUXB_ACC : MUXB_LOAD;
    end
    alu_reset_d = ((state_d == LOAD) || (state_d == EXEC)) && (alu_op_d == OP_RESET);
    rsp_valid_d = (state_d == RESP);

    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    last_d     = last_q;
    if (state_q == EXEC) begin
      if (alu_op_q == OP_RESET) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        last_d     = '0;
      end else if (cmd_err(alu_op_q, alu_b_q > alu_a_q, alu_b_q == '0)) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end else begin
        rsp_data_d = alu_acc_val;
        rsp_err_d  = 1'b0;
        last_d     = alu_acc_val[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      mux_a_q     <= MUXA_HOLD;
      mux_b_q     <= MUXB_HOLD;
      alu_op_q    <= OP_NOP;
      alu_reset_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      last_q      <= '0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      mux_a_q     <= mux_a_d;
      mux_b_q     <= mux_b_d;
      alu_op_q    <= alu_op_d;
      alu_reset_q <= alu_reset_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      last_q      <= last_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_mux_a = mux_a_q;
  assign alu_mux_b = mux_b_q;
  assign alu_op    = alu_op_q;
  assign alu_reset = alu_reset_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a small behavioural ALU; the skid
// scenario runs only when ALU_CMD_DRIVER_SKID_EN is defined.
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        cmd_chain = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_mux_a;
  logic [3:0]  alu_mux_b, alu_op;
  logic        alu_reset;
  logic [31:0] alu_acc_val;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Results captured by send()
  logic [31:0] r_d;
  logic        r_e;
  int          r_lat;
  logic [3:0]  r_mxb;
  logic [15:0] r_b;
  logic        r_ldrst, r_exrst, r_early;

  alu_cmd_driver #(.DW(16), .RW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_chain   (cmd_chain),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_mux_a   (alu_mux_a),
    .alu_mux_b   (alu_mux_b),
    .alu_op      (alu_op),
    .alu_reset   (alu_reset),
    .alu_acc_val (alu_acc_val),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: both load selects take the driver's alu_b value.
  logic [15:0] ra = 16'd0;
  logic [15:0] rb = 16'd0;
  always @(posedge clk) begin
    if (alu_reset) begin
      ra <= 16'd0;
      rb <= 16'd0;
    end else begin
      if (alu_mux_a == 2'b10) ra <= alu_a;
      if (alu_mux_b == 4'b0100 || alu_mux_b == 4'b0010) rb <= alu_b;
    end
  end

  always_comb begin
    alu_acc_val = 32'd0;
    case (alu_op)
      4'd0:  alu_acc_val = {16'd0, ra} + {16'd0, rb};
      4'd1:  alu_acc_val = {16'd0, ra} - {16'd0, rb};
      4'd2:  alu_acc_val = {16'd0, ra} * {16'd0, rb};
      4'd3:  alu_acc_val = (rb == 16'd0) ? 32'hFFFF_FFFF : {16'd0, ra / rb};
      4'd4:  alu_acc_val = {16'd0, ra & rb};
      4'd5:  alu_acc_val = {16'd0, ra | rb};
      4'd6:  alu_acc_val = {16'd0, ra ^ rb};
      4'd7:  alu_acc_val = {16'd0, ~ra};
      4'd8:  alu_acc_val = {16'd0, ~(ra & rb)};
      4'd9:  alu_acc_val = {16'd0, ~(ra | rb)};
      4'd10: alu_acc_val = {16'd0, ~(ra ^ rb)};
      4'd11: alu_acc_val = {16'd0, ra << rb[3:0]};
      4'd12: alu_acc_val = {16'd0, ra >> rb[3:0]};
      4'd13: alu_acc_val = {ra, rb};
      default: alu_acc_val = 32'd0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one command with rsp_ready as currently set; r_lat = -1 on timeout.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic chain);
    bit acc;
    acc = 1'b0;
    r_lat = -1;
    r_early = 1'b0;
    r_d = 32'hDEAD_BEEF;
    r_e = 1'bx;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    if (!acc) return;
    r_mxb = alu_mux_b; r_b = alu_b; r_ldrst = alu_reset; r_early = rsp_valid;
    step();
    r_exrst = alu_reset;
    r_early = r_early | rsp_valid;
    for (int i = 2; i < 20; i++) begin
      step();
      if (rsp_valid) begin
        r_lat = i;
        break;
      end
    end
    if (r_lat < 0) return;
    r_d = rsp_data;
    r_e = rsp_err;
    step();
  endtask

  task automatic test_reset();
    step(); step();
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
    n_tests++; if (alu_a !== 16'd0 || alu_b !== 16'd0) begin n_fail++; $display("FAIL rst_operands: got %h/%h expected 0/0", alu_a, alu_b); end
    n_tests++; if (alu_mux_a !== 2'b01 || alu_mux_b !== 4'b0001) begin n_fail++; $display("FAIL rst_mux: got %b/%b expected 01/0001", alu_mux_a, alu_mux_b); end
    n_tests++; if (alu_op !== 4'd13 || alu_reset !== 1'b0) begin n_fail++; $display("FAIL rst_op: got op=%0d rst=%b expected 13/0", alu_op, alu_reset); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got v=%b d=%h e=%b expected 0/0/0", rsp_valid, rsp_data, rsp_err); end
    reset = 1'b0;
    step();
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_add();
    send(4'd0, 16'd5, 16'd6, 1'b0);
    n_tests++; if (r_lat !== 2 || r_early !== 1'b0) begin n_fail++; $display("FAIL add_latency: got %0d early=%b expected 2 early=0", r_lat, r_early); end
    n_tests++; if (r_d !== 32'd11 || r_e !== 1'b0) begin n_fail++; $display("FAIL add_data: got %0d err=%b expected 11 err=0", r_d, r_e); end
    n_tests++; if (r_mxb !== 4'b0100) begin n_fail++; $display("FAIL add_mux_b: got %b expected 0100", r_mxb); end
  endtask

  task automatic test_chain();
    send(4'd2, 16'd300, 16'd300, 1'b0);
    n_tests++; if (r_d !== 32'd90000 || r_e !== 1'b0) begin n_fail++; $display("FAIL mul_data: got %0d err=%b expected 90000 err=0", r_d, r_e); end
    send(4'd0, 16'd1, 16'hFFFF, 1'b1);
    n_tests++; if (r_mxb !== 4'b0010 || r_b !== 16'd24464) begin n_fail++; $display("FAIL chain_load: got mux=%b b=%0d expected 0010/24464", r_mxb, r_b); end
    n_tests++; if (r_d !== 32'd24465 || r_e !== 1'b0) begin n_fail++; $display("FAIL chain_data: got %0d err=%b expected 24465 err=0", r_d, r_e); end
  endtask

  task automatic test_errors();
    send(4'd1, 16'd3, 16'd7, 1'b0);
    n_tests++; if (r_d !== 32'd0 || r_e !== 1'b1) begin n_fail++; $display("FAIL sub_err: got %h err=%b expected 0 err=1", r_d, r_e); end
    send(4'd3, 16'd10, 16'd0, 1'b0);
    n_tests++; if (r_d !== 32'd0 || r_e !== 1'b1) begin n_fail++; $display("FAIL div0_err: got %h err=%b expected 0 err=1", r_d, r_e); end
    send(4'd14, 16'd1, 16'd1, 1'b0);
    n_tests++; if (r_d !== 32'd0 || r_e !== 1'b1) begin n_fail++; $display("FAIL op14_err: got %h err=%b expected 0 err=1", r_d, r_e); end
    send(4'd0, 16'd2, 16'd0, 1'b1);
    n_tests++; if (r_d !== 32'd24467 || r_e !== 1'b0) begin n_fail++; $display("FAIL err_keeps_last: got %0d err=%b expected 24467 err=0", r_d, r_e); end
  endtask

  task automatic test_boundary();
    send(4'd1, 16'd7, 16'd7, 1'b0);
    n_tests++; if (r_d !== 32'd0 || r_e !== 1'b0) begin n_fail++; $display("FAIL sub_equal: got %h err=%b expected 0 err=0", r_d, r_e); end
    send(4'd3, 16'd9, 16'd3, 1'b0);
    n_tests++; if (r_d !== 32'd3 || r_e !== 1'b0) begin n_fail++; $display("FAIL div_ok: got %h err=%b expected 3 err=0", r_d, r_e); end
    send(4'd11, 16'd1, 16'd15, 1'b0);
    n_tests++; if (r_d !== 32'h8000 || r_e !== 1'b0) begin n_fail++; $display("FAIL shl15: got %h err=%b expected 8000 err=0", r_d, r_e); end
  endtask

  task automatic test_op_reset();
    send(4'd15, 16'd5, 16'd6, 1'b0);
    n_tests++; if (r_ldrst !== 1'b1 || r_exrst !== 1'b1) begin n_fail++; $display("FAIL op15_alu_reset: got %b/%b expected 1/1", r_ldrst, r_exrst); end
    n_tests++; if (r_d !== 32'd0 || r_e !== 1'b0) begin n_fail++; $display("FAIL op15_rsp: got %h err=%b expected 0 err=0", r_d, r_e); end
    n_tests++; if (alu_reset !== 1'b0) begin n_fail++; $display("FAIL op15_reset_drop: got %b expected 0", alu_reset); end
    send(4'd0, 16'd7, 16'd99, 1'b1);
    n_tests++; if (r_d !== 32'd7 || r_b !== 16'd0) begin n_fail++; $display("FAIL op15_clears_last: got %0d b=%0d expected 7 b=0", r_d, r_b); end
  endtask

  task automatic test_nop();
    send(4'd13, 16'h1234, 16'hABCD, 1'b0);
    n_tests++; if (r_d !== 32'h1234ABCD || r_e !== 1'b0) begin n_fail++; $display("FAIL nop_data: got %h err=%b expected 1234abcd err=0", r_d, r_e); end
  endtask

  task automatic test_backpressure();
    logic stable, rdy_ok;
    int   extra;
    rsp_ready = 1'b0;
    send(4'd6, 16'h00FF, 16'h0F0F, 1'b0);
    n_tests++; if (r_d !== 32'h0FF0 || r_e !== 1'b0) begin n_fail++; $display("FAIL bp_data: got %h err=%b expected 0ff0 err=0", r_d, r_e); end
    stable = 1'b1;
    rdy_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0FF0 || rsp_err !== 1'b0) stable = 1'b0;
`ifdef ALU_CMD_DRIVER_SKID_EN
      if (cmd_ready !== 1'b1) rdy_ok = 1'b0;
`else
      if (cmd_ready !== 1'b0) rdy_ok = 1'b0;
`endif
      step();
    end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b expected 1", stable); end
    n_tests++; if (rdy_ok !== 1'b1) begin n_fail++; $display("FAIL bp_cmd_ready: got %b expected 1", rdy_ok); end
    rsp_ready = 1'b1;
    step();
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) extra++;
      step();
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL bp_single_rsp: got %0d extra valid cycles expected 0", extra); end
  endtask

  task automatic test_reset_exec();
    int seen;
    cmd_op = 4'd0; cmd_a = 16'd100; cmd_b = 16'd200; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    n_tests++; if (alu_mux_a !== 2'b01 || alu_a !== 16'd100) begin n_fail++; $display("FAIL rx_in_exec: got mux=%b a=%0d expected 01/100", alu_mux_a, alu_a); end
    reset = 1'b1;
    #1;
    n_tests++; if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_op !== 4'd13 || alu_mux_a !== 2'b01 || alu_mux_b !== 4'b0001)
      begin n_fail++; $display("FAIL rx_async_alu: got a=%h b=%h op=%0d mux=%b/%b expected 0/0/13/01/0001", alu_a, alu_b, alu_op, alu_mux_a, alu_mux_b); end
    n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || rsp_data !== 32'd0) begin n_fail++; $display("FAIL rx_async_ctl: got v=%b rdy=%b d=%h expected 0/0/0", rsp_valid, cmd_ready, rsp_data); end
    step();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rx_dropped: got %0d valid cycles expected 0", seen); end
    send(4'd4, 16'hF0F0, 16'h0FF0, 1'b0);
    n_tests++; if (r_d !== 32'h00F0 || r_e !== 1'b0) begin n_fail++; $display("FAIL rx_and_after: got %h err=%b expected 00f0 err=0", r_d, r_e); end
  endtask

`ifdef ALU_CMD_DRIVER_SKID_EN
  task automatic test_skid();
    logic        rdy0, rdy1;
    int          n;
    int          t[2];
    logic [31:0] d[2];
    rsp_ready = 1'b1;
    cmd_op = 4'd0; cmd_a = 16'd2; cmd_b = 16'd3; cmd_chain = 1'b0; cmd_valid = 1'b1;
    rdy0 = cmd_ready;
    step();
    cmd_op = 4'd6; cmd_a = 16'h00F0; cmd_b = 16'h0F00;
    rdy1 = cmd_ready;
    step();
    cmd_valid = 1'b0;
    n = 0;
    t[0] = -1; t[1] = -1; d[0] = 32'd0; d[1] = 32'd0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) begin
        if (n < 2) begin t[n] = i; d[n] = rsp_data; end
        n++;
      end
      step();
    end
    n_tests++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL skid_no_stall: got %b/%b expected 1/1", rdy0, rdy1); end
    n_tests++; if (n !== 2 || (t[1] - t[0]) !== 3) begin n_fail++; $display("FAIL skid_spacing: got n=%0d gap=%0d expected 2/3", n, t[1] - t[0]); end
    n_tests++; if (d[0] !== 32'd5 || d[1] !== 32'h0FF0) begin n_fail++; $display("FAIL skid_order: got %h,%h expected 5,0ff0", d[0], d[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_errors();
    test_boundary();
    test_op_reset();
    test_nop();
    test_backpressure();
    test_reset_exec();
`ifdef ALU_CMD_DRIVER_SKID_EN
    test_skid();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
